// File: rtl/booth_mul_arb_if.sv
// ============================================================================
// booth_mul_arb_if : requester, multiplier and response signals of booth_mul_arb
// Rev 1.0
// ============================================================================
`default_nettype none

interface booth_mul_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic [7:0]  mul_multiplier;
  logic [7:0]  mul_multiplicand;
  logic [15:0] mul_product;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_product;
  logic        busy;
  logic [15:0] ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_product, rsp_ready,
    output req0_ready, req1_ready,
    output mul_multiplier, mul_multiplicand,
    output rsp_valid, rsp_id, rsp_product, busy, ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_product, rsp_ready,
    input  req0_ready, req1_ready,
    input  mul_multiplier, mul_multiplicand,
    input  rsp_valid, rsp_id, rsp_product, busy, ops_done
  );
endinterface

`default_nettype wire

// File: rtl/booth_mul_arb.sv
// ============================================================================
// booth_mul_arb : two-requester arbiter sharing one registered booth multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_mul_arb #(
  parameter int FIXED_PRI = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_mul_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        rsp_id_q;
  logic [15:0] rsp_product_q;
  logic [15:0] ops_done_q;
  logic [15:0] ops_done_d;
  logic        last_q;
  logic        busy_q;
  logic        rsp_valid_q;

  logic        w_any;
  logic        w_both;
  logic        w_gnt;
  logic        w_gnt_id;

  assign w_any  = bus.req0_valid | bus.req1_valid;
  assign w_both = bus.req0_valid & bus.req1_valid;
  // Ready is combinational, so it must be masked while reset holds the FSM.
  assign w_gnt  = rst_n & (state_q == IDLE) & w_any;

  generate
    if (FIXED_PRI != 0) begin : g_fixed
      assign w_gnt_id = ~bus.req0_valid;
    end else begin : g_rr
      assign w_gnt_id = w_both ? ~last_q : bus.req1_valid;
    end
  endgenerate

  assign ops_done_d = ops_done_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= 8'd0;
      b_q           <= 8'd0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= 16'd0;
      ops_done_q    <= 16'd0;
      last_q        <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_gnt) begin
            a_q      <= w_gnt_id ? bus.req1_a : bus.req0_a;
            b_q      <= w_gnt_id ? bus.req1_b : bus.req0_b;
            rsp_id_q <= w_gnt_id;
            last_q   <= w_gnt_id;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          state_q <= CAPT;
        end
        CAPT: begin
          // Multiplier registered its product on the CALC->CAPT edge.
          rsp_product_q <= bus.mul_product;
          rsp_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ops_done_q  <= ops_done_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready       = w_gnt & ~w_gnt_id;
  assign bus.req1_ready       = w_gnt &  w_gnt_id;
  assign bus.mul_multiplier   = a_q;
  assign bus.mul_multiplicand = b_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_id           = rsp_id_q;
  assign bus.rsp_product      = rsp_product_q;
  assign bus.busy             = busy_q;
  assign bus.ops_done         = ops_done_q;

endmodule

`default_nettype wire
